// File: rtl/ram_write_front_pkg.sv
// Shared definitions for the 32x4 memory-scan datapath: write-FSM encoding,
// default memory geometry and board clock constant.
package ram_write_front_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } wr_state_e;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 4;

    localparam int CLK_HZ          = 50_000_000;
    localparam int DEBOUNCE_10MS   = CLK_HZ / 100;

    localparam int DROP_W = 4;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ram_write_front_if.sv
// Write-request handshake between the write front-end (master) and the scan
// controller (slave): request held with address/data until acknowledged.
interface ram_write_front_if
    import ram_write_front_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/ram_write_front_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, stable level
// and a one-cycle pulse in the first cycle the stable level reads pressed.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_n_i,
    output logic btn_stable_o,
    output logic fall_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          fall_q, fall_d;
    logic          btn_s;

    assign btn_s = sync_q[1];

    // The count only survives while the synced level disagrees with the
    // stable one, so any bounce back to the old level restarts it.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        fall_d   = 1'b0;
        if (btn_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = btn_s;
            fall_d   = ~btn_s;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_n_i};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            fall_q   <= fall_d;
        end
    end

    assign btn_stable_o = stable_q;
    assign fall_o       = fall_q;
endmodule

// File: rtl/ram_write_front.sv
// Turns switches plus a debounced write button into one held write request
// per press; request stays up until the scan controller acks it.
module ram_write_front
    import ram_write_front_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int ADDR_W          = RAM_ADDR_W,
    parameter int DATA_W          = RAM_DATA_W
) (
    input  logic                CLOCK_50,
    input  logic                KEY0,
    input  logic [ADDR_W-1:0]   sw_addr,
    input  logic [DATA_W-1:0]   sw_data,
    input  logic                sw_en,
    input  logic                wr_btn_n,
    ram_write_front_if.master   wr_if,
    output logic                busy,
    output logic [ADDR_W-1:0]   last_addr,
    output logic [DATA_W-1:0]   last_data,
    output logic [DROP_W-1:0]   drop_cnt
);
    logic [ADDR_W-1:0] addr_s1_q, addr_s2_q;
    logic [DATA_W-1:0] data_s1_q, data_s2_q;
    logic              en_s1_q, en_s2_q;

    logic btn_stable, btn_fall, press;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] last_data_q, last_data_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i        (CLOCK_50),
        .rst_ni       (KEY0),
        .btn_n_i      (wr_btn_n),
        .btn_stable_o (btn_stable),
        .fall_o       (btn_fall)
    );

    assign press = btn_fall & ~btn_stable;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            addr_s1_q <= '0;
            addr_s2_q <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
            en_s1_q   <= 1'b0;
            en_s2_q   <= 1'b0;
        end else begin
            addr_s1_q <= sw_addr;
            addr_s2_q <= addr_s1_q;
            data_s1_q <= sw_data;
            data_s2_q <= data_s1_q;
            en_s1_q   <= sw_en;
            en_s2_q   <= en_s1_q;
        end
    end

    // Presses outside IDLE are never queued; they only bump the drop count.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        drop_d      = drop_q;
        unique case (state_q)
            IDLE: begin
                if (press && en_s2_q) begin
                    addr_d  = addr_s2_q;
                    data_d  = data_s2_q;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (press) begin
                    drop_d = sat_inc(drop_q);
                end
                if (wr_if.wr_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (press) begin
                    drop_d = sat_inc(drop_q);
                end
                last_addr_d = addr_q;
                last_data_d = data_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            last_addr_q <= '0;
            last_data_q <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            drop_q      <= drop_d;
        end
    end

    assign wr_if.wr_req  = (state_q == REQ);
    assign wr_if.wr_addr = addr_q;
    assign wr_if.wr_data = data_q;
    assign busy          = (state_q != IDLE);
    assign last_addr     = last_addr_q;
    assign last_data     = last_data_q;
    assign drop_cnt      = drop_q;
endmodule

// File: tb/tb_ram_write_front.sv
// Bench for ram_write_front with a 4-cycle debounce: directed vectors, timing
// corner cases and a randomized run against a transaction-level model.
module tb_ram_write_front;
    import ram_write_front_pkg::*;

    logic       clk = 1'b0;
    logic       KEY0 = 1'b1;
    logic [4:0] sw_addr = '0;
    logic [3:0] sw_data = '0;
    logic       sw_en = 1'b0;
    logic       wr_btn_n = 1'b1;
    logic       busy;
    logic [4:0] last_addr;
    logic [3:0] last_data;
    logic [3:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int req_rises = 0;

    ram_write_front_if #(.ADDR_W(5), .DATA_W(4)) wr_if ();

    ram_write_front #(
        .DEBOUNCE_CYCLES (4),
        .ADDR_W          (5),
        .DATA_W          (4)
    ) dut (
        .CLOCK_50  (clk),
        .KEY0      (KEY0),
        .sw_addr   (sw_addr),
        .sw_data   (sw_data),
        .sw_en     (sw_en),
        .wr_btn_n  (wr_btn_n),
        .wr_if     (wr_if.master),
        .busy      (busy),
        .last_addr (last_addr),
        .last_data (last_data),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge wr_if.wr_req) req_rises++;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic btn_pulse(input int lo, input int hi);
        wr_btn_n = 1'b0;
        repeat (lo) tick();
        wr_btn_n = 1'b1;
        repeat (hi) tick();
    endtask

    task automatic set_sw(input logic en, input logic [4:0] a, input logic [3:0] d);
        sw_en   = en;
        sw_addr = a;
        sw_data = d;
    endtask

    task automatic ack_pulse();
        wr_if.wr_ack = 1'b1;
        tick();
        wr_if.wr_ack = 1'b0;
        repeat (3) tick();
    endtask

    typedef struct {
        logic       en;
        logic [4:0] a;
        logic [3:0] d;
        logic       exp_req;
        logic [4:0] exp_last_a;
        logic [3:0] exp_last_d;
    } vec_t;

    vec_t vecs[6];

    // Transaction-level reference state
    logic       m_pend;
    logic [4:0] m_cap_a, m_last_a;
    logic [3:0] m_cap_d, m_last_d;
    int         m_drop;

    initial begin
        int r0;
        wr_if.wr_ack = 1'b0;

        vecs[0] = '{1'b1, 5'h13, 4'hA, 1'b1, 5'h13, 4'hA};
        vecs[1] = '{1'b0, 5'h07, 4'h3, 1'b0, 5'h13, 4'hA};
        vecs[2] = '{1'b1, 5'h1F, 4'hF, 1'b1, 5'h1F, 4'hF};
        vecs[3] = '{1'b1, 5'h00, 4'h0, 1'b1, 5'h00, 4'h0};
        vecs[4] = '{1'b0, 5'h1A, 4'h5, 1'b0, 5'h00, 4'h0};
        vecs[5] = '{1'b1, 5'h0C, 4'h6, 1'b1, 5'h0C, 4'h6};

        #2 KEY0 = 1'b0;
        tick();
        check("rst_req", wr_if.wr_req, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", wr_if.wr_addr, 0);
        check("rst_data", wr_if.wr_data, 0);
        check("rst_last", {last_addr, last_data}, 0);
        check("rst_drop", drop_cnt, 0);
        tick();
        KEY0 = 1'b1;
        repeat (3) tick();

        // Clean press: exact latency and ack-to-last timing
        set_sw(1'b1, 5'h13, 4'hA);
        repeat (3) tick();
        wr_btn_n = 1'b0;
        repeat (6) tick();
        check("press_lat_early", wr_if.wr_req, 0);
        tick();
        check("press_lat_req", wr_if.wr_req, 1);
        check("press_addr", wr_if.wr_addr, 5'h13);
        check("press_data", wr_if.wr_data, 4'hA);
        repeat (10) tick();
        wr_btn_n = 1'b1;
        repeat (10) tick();
        wr_if.wr_ack = 1'b1;
        tick();
        wr_if.wr_ack = 1'b0;
        check("done_req", wr_if.wr_req, 0);
        check("done_busy", busy, 1);
        check("done_last_old", last_addr, 0);
        tick();
        check("idle_busy", busy, 0);
        check("idle_last_a", last_addr, 5'h13);
        check("idle_last_d", last_data, 4'hA);
        repeat (3) tick();

        for (int i = 0; i < 6; i++) begin
            set_sw(vecs[i].en, vecs[i].a, vecs[i].d);
            repeat (3) tick();
            btn_pulse(10, 10);
            check($sformatf("vec%0d_req", i), wr_if.wr_req, vecs[i].exp_req);
            if (vecs[i].exp_req) begin
                check($sformatf("vec%0d_addr", i), wr_if.wr_addr, vecs[i].a);
                check($sformatf("vec%0d_data", i), wr_if.wr_data, vecs[i].d);
            end
            ack_pulse();
            check($sformatf("vec%0d_busy", i), busy, 0);
            check($sformatf("vec%0d_last_a", i), last_addr, vecs[i].exp_last_a);
            check($sformatf("vec%0d_last_d", i), last_data, vecs[i].exp_last_d);
            check($sformatf("vec%0d_drop", i), drop_cnt, 0);
        end

        // Ack while idle does nothing
        r0 = req_rises;
        ack_pulse();
        check("idle_ack_busy", busy, 0);
        check("idle_ack_rises", req_rises - r0, 0);
        check("idle_ack_last", {last_addr, last_data}, {5'h0C, 4'h6});

        // Ack held for five cycles
        set_sw(1'b1, 5'h15, 4'h2);
        repeat (3) tick();
        btn_pulse(10, 10);
        check("ack5_req", wr_if.wr_req, 1);
        r0 = req_rises;
        wr_if.wr_ack = 1'b1;
        tick();
        check("ack5_c1_req", wr_if.wr_req, 0);
        check("ack5_c1_busy", busy, 1);
        tick();
        check("ack5_c2_busy", busy, 0);
        check("ack5_c2_last", {last_addr, last_data}, {5'h15, 4'h2});
        repeat (3) tick();
        check("ack5_c5_busy", busy, 0);
        wr_if.wr_ack = 1'b0;
        tick();
        check("ack5_rises", req_rises - r0, 0);

        // Bouncy press: one request only
        set_sw(1'b1, 5'h0A, 4'h7);
        repeat (3) tick();
        r0 = req_rises;
        btn_pulse(2, 2);
        btn_pulse(2, 2);
        btn_pulse(12, 12);
        check("bounce_rises", req_rises - r0, 1);
        check("bounce_addr", wr_if.wr_addr, 5'h0A);
        ack_pulse();
        check("bounce_last", {last_addr, last_data}, {5'h0A, 4'h7});

        // Short glitches produce nothing
        r0 = req_rises;
        for (int k = 1; k <= 3; k++) btn_pulse(k, 10);
        check("glitch_rises", req_rises - r0, 0);
        check("glitch_busy", busy, 0);

        // Drop counter saturation with captured values held
        set_sw(1'b1, 5'h11, 4'h9);
        repeat (3) tick();
        btn_pulse(10, 10);
        for (int i = 0; i < 17; i++) begin
            set_sw(1'b1, 5'($urandom), 4'($urandom));
            btn_pulse(10, 10);
        end
        check("sat_drop", drop_cnt, 15);
        check("sat_req", wr_if.wr_req, 1);
        check("sat_addr", wr_if.wr_addr, 5'h11);
        check("sat_data", wr_if.wr_data, 4'h9);

        // Asynchronous reset mid-request
        @(negedge clk);
        #2 KEY0 = 1'b0;
        #1;
        check("arst_req", wr_if.wr_req, 0);
        check("arst_busy", busy, 0);
        check("arst_last", {last_addr, last_data}, 0);
        check("arst_drop", drop_cnt, 0);
        repeat (2) tick();
        KEY0 = 1'b1;
        repeat (3) tick();
        set_sw(1'b1, 5'h1C, 4'hE);
        repeat (3) tick();
        btn_pulse(10, 10);
        check("post_rst_req", wr_if.wr_req, 1);
        check("post_rst_addr", wr_if.wr_addr, 5'h1C);
        ack_pulse();
        check("post_rst_last", {last_addr, last_data}, {5'h1C, 4'hE});

        // Randomized run against the transaction model
        m_pend   = 1'b0;
        m_cap_a  = '0;
        m_cap_d  = '0;
        m_last_a = 5'h1C;
        m_last_d = 4'hE;
        m_drop   = 0;
        for (int s = 0; s < 60; s++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                btn_pulse($urandom_range(1, 3), 10);
            end else if (kind == 3) begin
                ack_pulse();
                if (m_pend) begin
                    m_last_a = m_cap_a;
                    m_last_d = m_cap_d;
                    m_pend   = 1'b0;
                end
            end else begin
                logic       en;
                logic [4:0] a;
                logic [3:0] d;
                en = ($urandom_range(0, 3) != 0);
                a  = 5'($urandom);
                d  = 4'($urandom);
                set_sw(en, a, d);
                repeat (3) tick();
                btn_pulse(10, 10);
                if (m_pend) begin
                    m_drop = (m_drop < 15) ? m_drop + 1 : 15;
                end else if (en) begin
                    m_pend  = 1'b1;
                    m_cap_a = a;
                    m_cap_d = d;
                end
            end
            check($sformatf("rnd%0d_req", s), wr_if.wr_req, m_pend);
            check($sformatf("rnd%0d_busy", s), busy, m_pend);
            check($sformatf("rnd%0d_drop", s), drop_cnt, m_drop);
            check($sformatf("rnd%0d_last", s), {last_addr, last_data}, {m_last_a, m_last_d});
            if (m_pend) begin
                check($sformatf("rnd%0d_cap", s), {wr_if.wr_addr, wr_if.wr_data}, {m_cap_a, m_cap_d});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_write_front.md
# ram_write_front

Upstream write-request stage for the 32×4 memory-scan datapath. It turns the board's slide switches and a write pushbutton into one clean, debounced write request, and holds that request until the scan controller acknowledges it in its write slot. It replaces the controller's practice of sampling the raw switch level at a fixed count, so every press produces exactly one write.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000 — cycles of stable button level required before accepting a change (10 ms at 50 MHz).
- ADDR_W, 5 — memory address width.
- DATA_W, 4 — memory data width.

Ports:
- CLOCK_50  in  1  — single system clock, 50 MHz.
- KEY0  in  1  — reset, asynchronous, active-low; wired from KEY[0].
- sw_addr  in  ADDR_W  — target address from SW[4:0]; asynchronous.
- sw_data  in  DATA_W  — write data from SW[8:5]; asynchronous.
- sw_en  in  1  — write enable level from SW[9]; asynchronous.
- wr_btn_n  in  1  — write pushbutton KEY[1], active-low, bouncy, asynchronous.
- wr_req  out  1  — write request to the scan controller.
- wr_addr  out  ADDR_W  — captured address; valid while wr_req=1.
- wr_data  out  DATA_W  — captured data; valid while wr_req=1.
- wr_ack  in  1  — controller has written wr_data at wr_addr; synchronous to CLOCK_50.
- busy  out  1  — request outstanding (state ≠ IDLE).
- last_addr  out  ADDR_W  — address of the last completed write, for HEX display.
- last_data  out  DATA_W  — data of the last completed write.
- drop_cnt  out  4  — presses rejected because busy; saturates at 15.

## Operation
- sw_addr, sw_data, sw_en and wr_btn_n each pass through a 2-flop synchronizer. The synchronizer for wr_btn_n resets to 1; all others reset to 0.
- Debounce:
  - btn_stable resets to 1 (released).
  - The counter clears whenever the synced button equals btn_stable.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES−1, btn_stable takes the synced value and the counter clears.
- A press event is a 1→0 transition of btn_stable. It lasts one cycle. Release transitions produce no event.
- FSM states:
  - IDLE: press event with synced sw_en=1 → capture synced sw_addr/sw_data into wr_addr/wr_data, go to REQ. A press event with sw_en=0 is ignored and not counted.
  - REQ: wr_req=1, wr_addr and wr_data held constant. wr_ack=1 → go to DONE. A press event here increments drop_cnt (saturating) and is otherwise discarded.
  - DONE: one cycle with wr_req=0. Copies wr_addr/wr_data into last_addr/last_data, then goes to IDLE. A press event in DONE is dropped and counted.
- wr_ack is ignored in IDLE and DONE.
- There is no timeout. The controller guarantees an ack within one scan slot (≤1 s).
- Reset values: wr_req=0, wr_addr=0, wr_data=0, busy=0, last_addr=0, last_data=0, drop_cnt=0. State is IDLE and the debounce counter is 0.

## Timing
- Latency from a clean button fall to btn_stable=0: 2 (sync) + DEBOUNCE_CYCLES cycles.
- wr_req rises on the clock edge after the press-event cycle.
- Address and data are sampled from the synchronizer outputs in the press-event cycle. Switch changes after that do not affect the pending request.
- Ack sampled high in cycle N:
  - cycle N+1: DONE, wr_req=0.
  - cycle N+2: IDLE, with last_addr/last_data updated.
- Minimum spacing between two wr_req assertions is 2 cycles. A request already high when the ack arrives is never extended.
- Reset asserted mid-request drops wr_req immediately (asynchronously). The pending write is lost and last_* return to 0.
- Bounce shorter than DEBOUNCE_CYCLES on either edge produces no event.

## Structure
- Shared package:
  - FSM state encoding: IDLE=2'd0, REQ=2'd1, DONE=2'd2.
  - Default ADDR_W and DATA_W, shared with the scan controller and the memory wrapper.
  - The 50 MHz clock constant.
- One sub-module, `debounce`, containing the synchronizer, counter and btn_stable register. It is parameterized by DEBOUNCE_CYCLES and outputs btn_stable and a one-cycle fall pulse.
- The top level holds the switch synchronizers, the FSM, the capture registers and the drop counter.

## Test plan
Simulation overrides DEBOUNCE_CYCLES=4 in all scenarios.
- Clean press, sw_en=1, sw_addr=5'h13, sw_data=4'hA → wr_req=1 with wr_addr=13, wr_data=A. After ack held 1 cycle: wr_req=0 next cycle, and last_addr=13, last_data=A one cycle later.
- Bouncy press, with 3 toggles each 2 cycles long before settling low → exactly one wr_req assertion. A glitch of 3 cycles or fewer alone → no request.
- Press with sw_en=0 → no wr_req and drop_cnt unchanged. Then sw_en=1 and a second press → request issued.
- Press accepted, then 17 further presses before any ack → drop_cnt=15 (saturated). wr_addr/wr_data are unchanged from the first capture even though the switches change.
- Ack pulsed while IDLE → no state change. Ack held high for 5 cycles in REQ → exactly one DONE cycle, then IDLE with wr_req=0.
- KEY0 low while in REQ → wr_req, busy and last_* go to 0 without waiting for a clock edge. After release, the FSM is in IDLE and the next press works normally.
